sm_accum: RTL and testbench
===========================

SM_ACCUM -- requirements
Module: sm_accum

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 4: width of the batch-length field; a batch holds at most 15 products.
REQ-002 The block SHALL have parameter ACC_W, default 12: width of the signed two's-complement accumulator.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: batch start request; sampled only in IDLE.
REQ-007 Port len, input, COUNT_W: number of products in the batch; sampled together with start.
REQ-008 Port in_valid, input, 1: product beat present on in_mag/in_sign.
REQ-009 Port in_ready, output, 1: block accepts a beat this cycle.
REQ-010 Port in_mag, input, 8: unsigned product magnitude from the multiplier output o.
REQ-011 Port in_sign, input, 1: product sign from the multiplier output s; 1 means negative.
REQ-012 Port acc_out, output, ACC_W: signed running or final sum.
REQ-013 Port ovf, output, 1: sticky saturation flag for the current batch.
REQ-014 Port busy, output, 1: high in ACCUM and DONE.
REQ-015 Port done, output, 1: one-cycle pulse marking the end of a batch.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and DONE.
REQ-017 In IDLE, start=1 with len!=0 SHALL clear acc_out and ovf, load the remaining count with len, and go to ACCUM next cycle.
REQ-018 In IDLE, start=1 with len=0 SHALL clear acc_out and ovf and go directly to DONE.
REQ-019 in_ready SHALL be 1 only in ACCUM, combinationally from state only, with no dependence on in_valid.
REQ-020 A beat SHALL be accepted when in_valid and in_ready are both 1; acc_out SHALL show the updated sum on the cycle after acceptance (1-cycle latency).
REQ-021 An accepted beat SHALL add in_mag when in_sign=0 and subtract in_mag when in_sign=1; magnitude 0 with sign 1 (negative zero) SHALL contribute 0.
REQ-022 The adder SHALL work at ACC_W+1 bits; a result above 2^(ACC_W-1)-1 SHALL saturate to that value, and a result below -2^(ACC_W-1) SHALL saturate to that value.
REQ-023 Any saturation SHALL set ovf, which SHALL stay set until the next accepted start or reset.
REQ-024 Cycles in ACCUM with in_valid=0 SHALL leave acc_out and the remaining count unchanged.
REQ-025 Acceptance of the beat that drops the remaining count to 0 SHALL move the FSM to DONE.
REQ-026 In DONE, done SHALL be 1 for exactly that one cycle; the FSM SHALL return to IDLE next cycle.
REQ-027 acc_out and ovf SHALL hold their final values in IDLE until the next accepted start.
REQ-028 start asserted in ACCUM or DONE SHALL be ignored, with no queuing.

Reset
REQ-029 While rst_n=0, the block SHALL force state=IDLE, acc_out=0, ovf=0, remaining count=0, done=0, busy=0 and in_ready=0, independent of clk.
REQ-030 Reset asserted mid-batch SHALL abandon the batch and SHALL NOT produce a done pulse.
REQ-031 After reset release, the first start SHALL be honoured on the first rising edge.

Structure
REQ-032 Package sm_accum_pkg SHALL hold the state enum (IDLE/ACCUM/DONE) and the ACC_MAX/ACC_MIN saturation constants as functions of ACC_W.
REQ-033 A combinational sub-module sm_to_tc SHALL convert {sign, 8-bit mag} to a signed (ACC_W+1)-bit value, mapping negative zero to 0; the saturating adder, counter and FSM SHALL stay in sm_accum.

Verification
REQ-034 Scenario: start, len=3; beats (6,+), (243,+), (1,-) -> acc_out=248, ovf=0, done pulse on the cycle after the third acceptance.
REQ-035 Scenario: len=9; nine beats (255,+) -> acc_out=2047, ovf=1. Repeat with (255,-) -> acc_out=-2048, ovf=1.
REQ-036 Scenario: len=2; beats (0,-), (0,+) with in_valid bubbles between them -> acc_out=0, in_ready=1 throughout ACCUM, done only after the second accepted beat.
REQ-037 Scenario: start with len=0 -> done next cycle, acc_out=0, in_ready never 1.
REQ-038 Scenario: len=3; accept (100,+) and (50,+), then pulse start (must be ignored), then drop rst_n -> acc_out=0, busy=0, in_ready=0, no done; a fresh start with len=1 and beat (3,-) -> acc_out=-3.

Source files
------------

// File: rtl/sm_accum_pkg.sv
// Shared types and saturation limits for the sign-magnitude accumulator.
package sm_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Saturation bounds of a w-bit two's-complement accumulator.
   function automatic int acc_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int acc_min(input int w);
      return -(1 << (w - 1));
   endfunction

   localparam int ACC_W_DEF = 12;
   localparam int ACC_MAX   = acc_max(ACC_W_DEF);
   localparam int ACC_MIN   = acc_min(ACC_W_DEF);

endpackage

// File: rtl/sm_accum_if.sv
// Batch control, product beat stream and result signals of sm_accum.
interface sm_accum_if #(
   parameter int COUNT_W = 4,
   parameter int ACC_W   = 12
);
   logic                      start;
   logic [COUNT_W-1:0]        len;
   logic                      in_valid;
   logic                      in_ready;
   logic [7:0]                in_mag;
   logic                      in_sign;
   logic signed [ACC_W-1:0]   acc_out;
   logic                      ovf;
   logic                      busy;
   logic                      done;

   modport master (
      output start, len, in_valid, in_mag, in_sign,
      input  in_ready, acc_out, ovf, busy, done
   );

   modport slave (
      input  start, len, in_valid, in_mag, in_sign,
      output in_ready, acc_out, ovf, busy, done
   );
endinterface

// File: rtl/sm_to_tc.sv
// Sign-magnitude product to signed two's-complement; negative zero maps to 0.
module sm_to_tc #(
   parameter int OUT_W = 13
) (
   input  logic                    i_sign,
   input  logic [7:0]              i_mag,
   output logic signed [OUT_W-1:0] o_val
);

   logic signed [OUT_W-1:0] w_mag_ext;

   assign w_mag_ext = signed'({{(OUT_W - 8){1'b0}}, i_mag});
   // Negate only a nonzero magnitude so a -0 beat contributes nothing.
   assign o_val = (i_sign && (i_mag != 8'd0)) ? -w_mag_ext : w_mag_ext;

endmodule

// File: rtl/sm_accum.sv
// Batch accumulator of signed products with saturation and sticky overflow.
module sm_accum
   import sm_accum_pkg::*;
#(
   parameter int COUNT_W = 4,
   parameter int ACC_W   = 12
) (
   input  logic     clk,
   input  logic     rst_n,
   sm_accum_if.slave bus
);

   // One extra bit of headroom lets a single beat's overshoot be detected.
   localparam int SUM_W = ACC_W + 1;
   localparam logic signed [SUM_W-1:0] L_MAX = SUM_W'(acc_max(ACC_W));
   localparam logic signed [SUM_W-1:0] L_MIN = SUM_W'(acc_min(ACC_W));

   state_t                   r_state;
   logic signed [ACC_W-1:0]  r_acc;
   logic                     r_ovf;
   logic [COUNT_W-1:0]       r_cnt;
   logic                     r_done;
   logic                     r_busy;

   logic signed [SUM_W-1:0]  w_beat;
   logic signed [SUM_W-1:0]  w_sum;
   logic                     w_hi;
   logic                     w_lo;
   logic                     w_accept;

   sm_to_tc #(.OUT_W(SUM_W)) u_to_tc (
      .i_sign (bus.in_sign),
      .i_mag  (bus.in_mag),
      .o_val  (w_beat)
   );

   assign w_sum    = $signed({r_acc[ACC_W-1], r_acc}) + w_beat;
   assign w_hi     = (w_sum > L_MAX);
   assign w_lo     = (w_sum < L_MIN);
   assign w_accept = bus.in_valid && (r_state == ACCUM);

   assign bus.in_ready = (r_state == ACCUM);
   assign bus.acc_out  = r_acc;
   assign bus.ovf      = r_ovf;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

   // Batch FSM with saturating accumulator, beat counter and registered flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_acc  <= '0;
                  r_ovf  <= 1'b0;
                  r_busy <= 1'b1;
                  if (bus.len != '0) begin
                     r_cnt   <= bus.len;
                     r_state <= ACCUM;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            ACCUM: begin
               if (w_accept) begin
                  if (w_hi) begin
                     r_acc <= L_MAX[ACC_W-1:0];
                     r_ovf <= 1'b1;
                  end else if (w_lo) begin
                     r_acc <= L_MIN[ACC_W-1:0];
                     r_ovf <= 1'b1;
                  end else begin
                     r_acc <= w_sum[ACC_W-1:0];
                  end
                  r_cnt <= r_cnt - COUNT_W'(1);
                  if (r_cnt == COUNT_W'(1)) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sm_accum.sv
// Scoreboard bench for sm_accum: expected batch results are queued as beats
// are driven and compared when the done pulse appears.
module tb_sm_accum;

   typedef struct {
      int acc;
      bit ovf;
   } exp_t;

   logic clk;
   logic rst_n;

   sm_accum_if #(.COUNT_W(4), .ACC_W(12)) bus ();

   sm_accum #(.COUNT_W(4), .ACC_W(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errs   = 0;
   int   n_done   = 0;
   int   n_pushed = 0;
   int   model_acc = 0;
   bit   model_ovf = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference arithmetic: add/subtract then clamp to the 12-bit signed range.
   function automatic void model_add(input int mag, input bit sgn);
      int s;
      s = model_acc + (sgn ? -mag : mag);
      if (s > 2047) begin
         s = 2047;
         model_ovf = 1'b1;
      end else if (s < -2048) begin
         s = -2048;
         model_ovf = 1'b1;
      end
      model_acc = s;
   endfunction

   function automatic void push_expected();
      exp_t e;
      e.acc = model_acc;
      e.ovf = model_ovf;
      sb_q.push_back(e);
      n_pushed++;
   endfunction

   // Every done pulse must match the oldest queued batch result.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         exp_t e;
         n_done++;
         if (sb_q.size() == 0) begin
            check_val("unexp_done", bus.done, 0);
         end else begin
            e = sb_q.pop_front();
            check_val("sb_acc", bus.acc_out, e.acc);
            check_val("sb_ovf", bus.ovf, e.ovf);
            $display("batch %0d done acc=%0d ovf=%0d", n_done, bus.acc_out, bus.ovf);
         end
      end
   end

   task automatic do_start(input int n);
      bus.start = 1'b1;
      bus.len   = 4'(n);
      model_acc = 0;
      model_ovf = 1'b0;
      if (n == 0) push_expected();
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_val("busy_start", bus.busy, 1);
      check_val("acc_clear", bus.acc_out, 0);
      check_val("ovf_clear", bus.ovf, 0);
   endtask

   task automatic send_beat(input int mag, input bit sgn, input bit last);
      int waited = 0;
      bus.in_valid = 1'b1;
      bus.in_mag   = 8'(mag);
      bus.in_sign  = sgn;
      @(negedge clk);
      while (!bus.in_ready && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      check_val("rdy", bus.in_ready, 1);
      model_add(mag, sgn);
      if (last) push_expected();
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check_val("acc_run", bus.acc_out, model_acc);
      check_val("ovf_run", bus.ovf, model_ovf);
   endtask

   // Called right after the edge that entered DONE.
   task automatic finish_batch();
      check_val("done_pulse", bus.done, 1);
      check_val("rdy_done", bus.in_ready, 0);
      @(posedge clk);
      #1;
      check_val("done_clr", bus.done, 0);
      check_val("busy_idle", bus.busy, 0);
      check_val("acc_hold", bus.acc_out, model_acc);
      check_val("ovf_hold", bus.ovf, model_ovf);
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.len      = '0;
      bus.in_valid = 1'b0;
      bus.in_mag   = '0;
      bus.in_sign  = 1'b0;
      #2;
      check_val("rst_acc", bus.acc_out, 0);
      check_val("rst_ovf", bus.ovf, 0);
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_done", bus.done, 0);
      check_val("rst_rdy", bus.in_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Mixed signs, no saturation.
      do_start(3);
      send_beat(6, 0, 0);
      send_beat(243, 0, 0);
      send_beat(1, 1, 1);
      check_val("sc1_acc", bus.acc_out, 248);
      finish_batch();

      // Positive then negative saturation.
      do_start(9);
      for (int i = 0; i < 9; i++) send_beat(255, 0, i == 8);
      check_val("sat_hi", bus.acc_out, 2047);
      finish_batch();
      do_start(9);
      for (int i = 0; i < 9; i++) send_beat(255, 1, i == 8);
      check_val("sat_lo", bus.acc_out, -2048);
      finish_batch();

      // Zero-length batch: done next cycle, clears previous saturated result.
      do_start(0);
      check_val("len0_done", bus.done, 1);
      check_val("len0_rdy", bus.in_ready, 0);
      @(posedge clk);
      #1;
      check_val("len0_clr", bus.done, 0);
      check_val("len0_rdy2", bus.in_ready, 0);
      check_val("len0_acc", bus.acc_out, 0);

      // Negative zero and valid bubbles.
      do_start(2);
      send_beat(0, 1, 0);
      repeat (3) begin
         @(negedge clk);
         check_val("bub_rdy", bus.in_ready, 1);
         check_val("bub_done", bus.done, 0);
         check_val("bub_acc", bus.acc_out, 0);
      end
      @(posedge clk);
      #1;
      send_beat(0, 0, 1);
      finish_batch();

      // Ignored start mid-batch, then reset abandons the batch.
      do_start(3);
      send_beat(100, 0, 0);
      send_beat(50, 0, 0);
      bus.start = 1'b1;
      bus.len   = 4'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_val("ign_acc", bus.acc_out, 150);
      check_val("ign_busy", bus.busy, 1);
      check_val("ign_rdy", bus.in_ready, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_acc", bus.acc_out, 0);
      check_val("arst_busy", bus.busy, 0);
      check_val("arst_rdy", bus.in_ready, 0);
      check_val("arst_done", bus.done, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_start(1);
      check_val("post_rst_rdy", bus.in_ready, 1);
      send_beat(3, 1, 1);
      check_val("post_rst_acc", bus.acc_out, -3);
      finish_batch();

      repeat (3) @(posedge clk);
      #1;
      check_val("done_count", n_done, n_pushed);
      check_val("sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
